phase_unwrap_track: RTL and testbench



---
 rtl/phase_unwrap_track.sv | 186 ++++++++++++++++++
 tb/tb_phase_unwrap_track.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/phase_unwrap_track.sv
// Unwraps the CORDIC phase into a wide running phase and tracks frequency as a moving sum of deltas.
// Samples are qualified by magnitude. Lock and hold status are tracked, and results leave over valid/ready.
module phase_unwrap_track #(
   parameter int unsigned PW       = 19,
   parameter int unsigned MW       = 12,
   parameter int unsigned AW       = 32,
   parameter int unsigned AVG_LOG2 = 3,
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_ce,
   input  logic                   i_valid,
   input  logic [MW-1:0]          i_mag,
   input  logic [PW-1:0]          i_phase,
   input  logic [MW-1:0]          i_mag_thresh,
   input  logic                   i_clear,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [AW-1:0]          o_phase_acc,
   output logic [PW+AVG_LOG2-1:0] o_freq,
   output logic                   o_locked,
   output logic                   o_overrun
);

   localparam int unsigned DEPTH = 1 << AVG_LOG2;
   localparam int unsigned FW    = PW + AVG_LOG2;
   localparam int unsigned GW    = AVG_LOG2 + 1;
   localparam int unsigned WW    = 8;

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_TRACK   = 2'd1,
      ST_HOLD    = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [PW-1:0]       prev_q, prev_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [FW-1:0]       sum_q, sum_d;
   logic [PW-1:0]       dl_q [DEPTH];
   logic [PW-1:0]       dl_d [DEPTH];
   logic [AVG_LOG2-1:0] ptr_q, ptr_d;
   logic [GW-1:0]       good_q, good_d;
   logic [WW-1:0]       weak_q, weak_d;
   logic                locked_q, locked_d;
   logic                ovr_q, ovr_d;
   logic                ovalid_q, ovalid_d;
   logic [AW-1:0]       oacc_q, oacc_d;
   logic [FW-1:0]       ofreq_q, ofreq_d;

   logic                accept_c, strong_c, weak_c, emit_c;
   logic [PW-1:0]       delta_c;
   logic [WW-1:0]       weak_inc_c;

   // Modular difference; its top bit doubles as the sign, so a half turn reads negative.
   assign accept_c   = i_ce && i_valid;
   assign strong_c   = accept_c && !i_mag[MW-1] && (i_mag >= i_mag_thresh);
   assign weak_c     = accept_c && !strong_c;
   assign delta_c    = i_phase - prev_q;
   assign weak_inc_c = (state_q == ST_TRACK) ? WW'(1) : weak_q + WW'(1);

   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      acc_d    = acc_q;
      sum_d    = sum_q;
      dl_d     = dl_q;
      ptr_d    = ptr_q;
      good_d   = good_q;
      weak_d   = weak_q;
      locked_d = locked_q;
      ovr_d    = ovr_q;
      ovalid_d = ovalid_q;
      oacc_d   = oacc_q;
      ofreq_d  = ofreq_q;
      emit_c   = 1'b0;

      if (i_clear) begin
         state_d  = ST_ACQUIRE;
         acc_d    = '0;
         sum_d    = '0;
         for (int i = 0; i < DEPTH; i++) dl_d[i] = '0;
         ptr_d    = '0;
         good_d   = '0;
         weak_d   = '0;
         locked_d = 1'b0;
         ovr_d    = 1'b0;
         ovalid_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_ACQUIRE: begin
               if (strong_c) begin
                  prev_d  = i_phase;
                  acc_d   = AW'(i_phase);
                  good_d  = '0;
                  weak_d  = '0;
                  state_d = ST_TRACK;
               end
            end
            ST_TRACK, ST_HOLD: begin
               if (strong_c) begin
                  acc_d       = acc_q + {{(AW-PW){delta_c[PW-1]}}, delta_c};
                  prev_d      = i_phase;
                  sum_d       = sum_q - {{AVG_LOG2{dl_q[ptr_q][PW-1]}}, dl_q[ptr_q]}
                                      + {{AVG_LOG2{delta_c[PW-1]}}, delta_c};
                  dl_d[ptr_q] = delta_c;
                  ptr_d       = ptr_q + AVG_LOG2'(1);
                  if (good_q != GW'(DEPTH)) good_d = good_q + GW'(1);
                  if (good_d == GW'(DEPTH)) locked_d = 1'b1;
                  weak_d      = '0;
                  state_d     = ST_TRACK;
                  emit_c      = 1'b1;
               end else if (weak_c) begin
                  weak_d = weak_inc_c;
                  if (weak_inc_c >= WW'(HOLD_MAX)) begin
                     // Gap too long: drop lock and history, reseed on next strong sample.
                     state_d  = ST_ACQUIRE;
                     locked_d = 1'b0;
                     sum_d    = '0;
                     for (int i = 0; i < DEPTH; i++) dl_d[i] = '0;
                     ptr_d    = '0;
                     good_d   = '0;
                     weak_d   = '0;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end
            end
            default: state_d = ST_ACQUIRE;
         endcase

         // Single output register; a record arriving while a stalled one is held is dropped.
         if (emit_c) begin
            if (ovalid_q && !i_ready) begin
               ovr_d = 1'b1;
            end else begin
               ovalid_d = 1'b1;
               oacc_d   = acc_d;
               ofreq_d  = sum_d;
            end
         end else if (ovalid_q && i_ready) begin
            ovalid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= ST_ACQUIRE;
         prev_q   <= '0;
         acc_q    <= '0;
         sum_q    <= '0;
         for (int i = 0; i < DEPTH; i++) dl_q[i] <= '0;
         ptr_q    <= '0;
         good_q   <= '0;
         weak_q   <= '0;
         locked_q <= 1'b0;
         ovr_q    <= 1'b0;
         ovalid_q <= 1'b0;
         oacc_q   <= '0;
         ofreq_q  <= '0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         acc_q    <= acc_d;
         sum_q    <= sum_d;
         dl_q     <= dl_d;
         ptr_q    <= ptr_d;
         good_q   <= good_d;
         weak_q   <= weak_d;
         locked_q <= locked_d;
         ovr_q    <= ovr_d;
         ovalid_q <= ovalid_d;
         oacc_q   <= oacc_d;
         ofreq_q  <= ofreq_d;
      end
   end

   assign o_valid     = ovalid_q;
   assign o_phase_acc = oacc_q;
   assign o_freq      = ofreq_q;
   assign o_locked    = locked_q;
   assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_phase_unwrap_track.sv
// Directed bench for phase_unwrap_track: unwrap across the wrap point, half-turn delta, hold/reacquire,
// backpressure overrun, clear and asynchronous reset.
module tb_phase_unwrap_track;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce, vld, clr, rdy;
   logic [11:0] mag, thresh;
   logic [18:0] ph;
   logic        o_valid, o_locked, o_overrun;
   logic [31:0] o_acc;
   logic [21:0] o_freq;

   int n_checks = 0;
   int n_fail   = 0;
   int nv;

   always #5 clk = ~clk;

   phase_unwrap_track dut (
      .i_clk        (clk),
      .i_reset      (rst_n),
      .i_ce         (ce),
      .i_valid      (vld),
      .i_mag        (mag),
      .i_phase      (ph),
      .i_mag_thresh (thresh),
      .i_clear      (clr),
      .o_valid      (o_valid),
      .i_ready      (rdy),
      .o_phase_acc  (o_acc),
      .o_freq       (o_freq),
      .o_locked     (o_locked),
      .o_overrun    (o_overrun)
   );

   function automatic logic [31:0] a32(input int x);
      return 32'(x);
   endfunction

   function automatic logic [21:0] f22(input int x);
      return 22'(x);
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [31:0] acc, input logic [21:0] fr,
                            input logic lk);
      check_eq({tag, "_valid"}, 64'(o_valid), 64'(1));
      check_eq({tag, "_acc"}, 64'(o_acc), 64'(acc));
      check_eq({tag, "_freq"}, 64'(o_freq), 64'(fr));
      check_eq({tag, "_locked"}, 64'(o_locked), 64'(lk));
   endtask

   task automatic drive(input logic [18:0] p, input logic [11:0] m);
      @(negedge clk);
      vld = 1'b1;
      ph  = p;
      mag = m;
      @(posedge clk);
      #1;
      vld = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; ce = 1'b1; vld = 1'b0; clr = 1'b0; rdy = 1'b1;
      mag = '0; ph = '0; thresh = 12'h100;
      #12;
      check_eq("rst_valid", 64'(o_valid), 64'(0));
      check_eq("rst_acc", 64'(o_acc), 64'(0));
      check_eq("rst_freq", 64'(o_freq), 64'(0));
      check_eq("rst_locked", 64'(o_locked), 64'(0));
      check_eq("rst_overrun", 64'(o_overrun), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Ramp +0x1000 per sample across the phase wrap
      drive(19'h7E000, 12'h400);
      check_eq("seed_novalid", 64'(o_valid), 64'(0));
      for (int k = 1; k <= 9; k++) begin
         drive(19'((32'h7E000 + k * 32'h1000) & 32'h7FFFF), 12'h400);
         check_out($sformatf("ramp%0d", k), a32(32'h7E000 + k * 32'h1000),
                   f22(((k < 8) ? k : 8) * 32'h1000), logic'(k >= 8));
      end

      // Exact half turn reads as a negative delta
      drive(19'h47000, 12'h400);
      check_out("half", 32'h00047000, f22(-32'sh39000), 1'b1);

      do_clear();
      check_eq("clr_valid", 64'(o_valid), 64'(0));
      check_eq("clr_locked", 64'(o_locked), 64'(0));

      // Step -0x800 per sample from 0x00400
      drive(19'h00400, 12'h400);
      check_eq("seed2_novalid", 64'(o_valid), 64'(0));
      for (int k = 1; k <= 8; k++) begin
         drive(19'((32'h400 - k * 32'h800) & 32'h7FFFF), 12'h400);
         check_out($sformatf("step%0d", k), a32(32'h400 - k * 32'h800),
                   f22(-k * 32'h800), logic'(k == 8));
      end

      // Samples without clock enable are ignored
      @(negedge clk);
      ce = 1'b0; vld = 1'b1; ph = 19'h00000; mag = 12'h400;
      @(posedge clk);
      #1;
      ce = 1'b1; vld = 1'b0;
      check_eq("ce_ignored", 64'(o_valid), 64'(0));

      // 15 weak samples then strong: tracking resumes, delta against pre-gap phase
      nv = 0;
      for (int i = 0; i < 15; i++) begin
         drive(19'h7C400, 12'h050);
         nv += int'(o_valid);
      end
      check_eq("holdA_nvalid", 64'(nv), 64'(0));
      check_eq("holdA_locked", 64'(o_locked), 64'(1));
      drive(19'h7C500, 12'h400);
      check_out("holdA_resume", 32'hFFFFC500, f22(-32'sh3700), 1'b1);

      // 16 weak samples: lock lost on the 16th, then reacquire
      nv = 0;
      for (int i = 1; i <= 16; i++) begin
         drive(19'h7C500, 12'h050);
         nv += int'(o_valid);
         if (i == 15) check_eq("holdB_locked15", 64'(o_locked), 64'(1));
      end
      check_eq("holdB_nvalid", 64'(nv), 64'(0));
      check_eq("holdB_locked16", 64'(o_locked), 64'(0));
      drive(19'h55555, 12'hFFF);
      drive(19'h12345, 12'h400);
      check_eq("reseed_novalid", 64'(o_valid), 64'(0));
      drive(19'h12445, 12'h100);
      check_out("reseed_first", 32'h00012445, 22'h000100, 1'b0);
      drive(19'h12545, 12'h0FF);
      check_eq("below_thresh", 64'(o_valid), 64'(0));

      // Backpressure: first record held, second dropped, then load with handshake
      rdy = 1'b0;
      drive(19'h12545, 12'h400);
      check_out("bp_first", 32'h00012545, 22'h000200, 1'b0);
      check_eq("bp_ovr0", 64'(o_overrun), 64'(0));
      drive(19'h12645, 12'h400);
      check_eq("bp_held_valid", 64'(o_valid), 64'(1));
      check_eq("bp_held_acc", 64'(o_acc), 64'(32'h12545));
      check_eq("bp_ovr1", 64'(o_overrun), 64'(1));
      rdy = 1'b1;
      drive(19'h12745, 12'h400);
      check_out("bp_reload", 32'h00012745, 22'h000400, 1'b0);
      check_eq("bp_ovr_sticky", 64'(o_overrun), 64'(1));
      do_clear();
      check_eq("clr2_ovr", 64'(o_overrun), 64'(0));
      check_eq("clr2_valid", 64'(o_valid), 64'(0));

      // Asynchronous reset mid-record
      drive(19'h10000, 12'h400);
      drive(19'h11000, 12'h400);
      check_eq("pre_rst_valid", 64'(o_valid), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid", 64'(o_valid), 64'(0));
      check_eq("arst_acc", 64'(o_acc), 64'(0));
      check_eq("arst_freq", 64'(o_freq), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      drive(19'h20000, 12'h400);
      check_eq("post_rst_seed", 64'(o_valid), 64'(0));
      drive(19'h20800, 12'h400);
      check_out("post_rst", 32'h00020800, 22'h000800, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
